// File: rtl/test_mailbox_pkg.sv
// Shared types and defaults for the test mailbox: FSM state encoding, status byte layout
// and the default mailbox window addresses.
package test_mailbox_pkg;

  typedef enum logic [1:0] {
    RUN,
    PASS,
    FAIL,
    TIMEOUT
  } mailbox_state_t;

  localparam int unsigned DONE_BIT    = 7;
  localparam int unsigned PASS_BIT    = 6;
  localparam int unsigned FAIL_BIT    = 5;
  localparam int unsigned TIMEOUT_BIT = 4;

  localparam logic [15:0] DEF_PROGRESS_ADDR  = 16'h0070;
  localparam logic [15:0] DEF_RESULT_ADDR    = 16'h0071;
  localparam logic [15:0] DEF_STATUS_ADDR    = 16'h0072;
  localparam logic [7:0]  DEF_PASS_CODE      = 8'hFF;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 4096;
  localparam int unsigned DEF_CNT_W          = 16;

  function automatic logic [7:0] status_byte(input logic       done,
                                             input logic       pass,
                                             input logic       fail,
                                             input logic       timeout,
                                             input logic [3:0] wcount);
    logic [7:0] s;
    s              = {4'h0, wcount};
    s[DONE_BIT]    = done;
    s[PASS_BIT]    = pass;
    s[FAIL_BIT]    = fail;
    s[TIMEOUT_BIT] = timeout;
    return s;
  endfunction

endpackage

// File: rtl/mailbox_watchdog.sv
// Watchdog counter: counts enabled clocks since the last clear and flags expiry when the
// count sits at TIMEOUT_CYCLES-1 on an enabled, non-clearing edge.
module mailbox_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic ph2,
  input  logic resetb,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != LAST)) begin
      count_d = count_q + 1'b1;
    end
  end

  // A clear on the same edge wins over expiry.
  assign expire = enable && !clear && (count_q == LAST);

  always_ff @(posedge ph2) begin
    if (!resetb) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/test_mailbox.sv
// Zero-page test mailbox: snoops CPU writes for progress/verdict, runs a hang watchdog and
// answers status reads with a one-clock-delayed status byte.
module test_mailbox
  import test_mailbox_pkg::*;
#(
  parameter logic [15:0] PROGRESS_ADDR  = DEF_PROGRESS_ADDR,
  parameter logic [15:0] RESULT_ADDR    = DEF_RESULT_ADDR,
  parameter logic [15:0] STATUS_ADDR    = DEF_STATUS_ADDR,
  parameter logic [7:0]  PASS_CODE      = DEF_PASS_CODE,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned CNT_W          = DEF_CNT_W
) (
  input  logic             ph2,
  input  logic             resetb,
  input  logic [15:0]      address,
  input  logic [7:0]       wdata,
  input  logic             memwrite,
  input  logic             memread,
  output logic [7:0]       rdata,
  output logic             rdata_valid,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [7:0]       result_code,
  output logic [7:0]       checkpoint,
  output logic [7:0]       write_count,
  output logic [CNT_W-1:0] cycle_count
);

  mailbox_state_t state_q, state_d;

  logic [7:0]       result_q, result_d;
  logic [7:0]       checkpoint_q, checkpoint_d;
  logic [7:0]       wcount_q, wcount_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;

  logic in_run, result_wr, progress_wr, status_rd, wd_expire;

  assign in_run      = (state_q == RUN);
  assign result_wr   = memwrite && (address == RESULT_ADDR);
  assign progress_wr = memwrite && (address == PROGRESS_ADDR);
  assign status_rd   = memread && (address == STATUS_ADDR);

  mailbox_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .ph2   (ph2),
    .resetb(resetb),
    .clear (in_run && progress_wr),
    .enable(in_run),
    .expire(wd_expire)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (result_wr) begin
          state_d = (wdata == PASS_CODE) ? PASS : FAIL;
        end else if (wd_expire) begin
          state_d = TIMEOUT;
        end
      end
      PASS, FAIL, TIMEOUT: state_d = state_q;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    result_d     = result_q;
    checkpoint_d = checkpoint_q;
    wcount_d     = wcount_q;
    cycles_d     = cycles_q;
    if (in_run) begin
      if (cycles_q != {CNT_W{1'b1}}) begin
        cycles_d = cycles_q + 1'b1;
      end
      if (result_wr) begin
        result_d = wdata;
      end else if (progress_wr) begin
        checkpoint_d = wdata;
        if (wcount_q != 8'hFF) begin
          wcount_d = wcount_q + 8'd1;
        end
      end
    end
  end

  assign done    = (state_q != RUN);
  assign pass    = (state_q == PASS);
  assign fail    = (state_q == FAIL);
  assign timeout = (state_q == TIMEOUT);

  // Status is captured from current (pre-write) state at the read edge.
  always_comb begin
    rdata_d  = 8'h00;
    rvalid_d = 1'b0;
    if (status_rd) begin
      rdata_d  = status_byte(done, pass, fail, timeout, wcount_q[3:0]);
      rvalid_d = 1'b1;
    end
  end

  always_ff @(posedge ph2) begin
    if (!resetb) begin
      state_q      <= RUN;
      result_q     <= 8'h00;
      checkpoint_q <= 8'h00;
      wcount_q     <= 8'h00;
      cycles_q     <= '0;
      rdata_q      <= 8'h00;
      rvalid_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      result_q     <= result_d;
      checkpoint_q <= checkpoint_d;
      wcount_q     <= wcount_d;
      cycles_q     <= cycles_d;
      rdata_q      <= rdata_d;
      rvalid_q     <= rvalid_d;
    end
  end

  assign rdata       = rdata_q;
  assign rdata_valid = rvalid_q;
  assign result_code = result_q;
  assign checkpoint  = checkpoint_q;
  assign write_count = wcount_q;
  assign cycle_count = cycles_q;

endmodule
